// File: rtl/dmem_result_checker.sv
// Purpose : end-of-program checker; waits for the fetch PC to reach the program end (or times out),
//           then reads DEPTH data words and compares each against an answer ROM.
// Latency : first read strobe one cycle after the eof edge E; verdict (done_o) registered at E+DEPTH+2.
// Backpressure: none; memories are read one word per cycle and data is expected the following cycle.
module dmem_result_checker #(
    parameter int          DEPTH     = 36,
    parameter logic [31:0] DATA_BASE = 32'h1001_0000,
    parameter int          TIMEOUT   = 1000,
    parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      eof_addr_i,
    output logic             rd_en_o,
    output logic [31:0]      rd_addr_o,
    input  logic [31:0]      dut_rdata_i,
    input  logic [31:0]      ans_rdata_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [31:0]      first_err_addr_o,
    output logic [31:0]      first_err_dut_o,
    output logic [31:0]      first_err_ans_o
);

    localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(DEPTH - 1);
    localparam logic [TW-1:0] CYC_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    cyc_q;
    logic [KW-1:0]    k_q;
    logic             cmp_vld_q;
    logic [KW-1:0]    cmp_idx_q;
    logic             done_q;
    logic             pass_q;
    logic             timeout_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [31:0]      first_addr_q;
    logic [31:0]      first_dut_q;
    logic [31:0]      first_ans_q;

    logic [31:0]      rd_addr_d;
    logic [31:0]      cmp_addr_d;
    logic             mismatch_d;

    // Read address follows the scan index directly so the strobe and address line up in the same cycle.
    always_comb begin
        rd_addr_d  = DATA_BASE + (32'(k_q) << 2);
        cmp_addr_d = DATA_BASE + (32'(cmp_idx_q) << 2);
        mismatch_d = cmp_vld_q && (dut_rdata_i != ans_rdata_i);
    end

    assign rd_en_o          = (state_q == ST_SCAN);
    assign rd_addr_o        = (state_q == ST_SCAN) ? rd_addr_d : 32'h0;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_addr_q;
    assign first_err_dut_o  = first_dut_q;
    assign first_err_ans_o  = first_ans_q;

    // Control FSM, one-cycle compare pipeline and registered verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            k_q          <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_idx_q    <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= '0;
            first_addr_q <= '0;
            first_dut_q  <= '0;
            first_ans_q  <= '0;
        end else begin
            // Read data returns one cycle after the strobe, so the flag and index trail by one cycle.
            cmp_vld_q <= (state_q == ST_SCAN);
            cmp_idx_q <= k_q;

            // Count cannot wrap: at most DEPTH mismatches and CNT_W holds DEPTH.
            if (mismatch_d) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
                if (err_cnt_q == '0) begin
                    first_addr_q <= cmp_addr_d;
                    first_dut_q  <= dut_rdata_i;
                    first_ans_q  <= ans_rdata_i;
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        state_q      <= ST_RUN;
                        cyc_q        <= '0;
                        k_q          <= '0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        err_cnt_q    <= '0;
                        first_addr_q <= '0;
                        first_dut_q  <= '0;
                        first_ans_q  <= '0;
                    end
                end
                ST_RUN: begin
                    // eof takes priority over a timeout landing in the same cycle.
                    if (pc_i == eof_addr_i) begin
                        state_q <= ST_SCAN;
                        k_q     <= '0;
                    end else if (cyc_q == CYC_LAST) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end else begin
                        cyc_q <= cyc_q + TW'(1);
                    end
                end
                ST_SCAN: begin
                    if (k_q == K_LAST) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                ST_DRAIN: begin
                    // Stay until the last word's compare has been folded into the error count.
                    if (!cmp_vld_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_q == '0) && !timeout_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
